// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermometer-code monitor.
// Widths, the saturating count limit and the FSM state encoding live here.
package thermo_pkg;

  localparam int DATA_W  = 8;
  localparam int LEVEL_W = 4;
  localparam int CNT_W   = 8;

  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DATA_W);
  localparam logic [CNT_W-1:0]   COUNT_MAX  = 8'd255;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/thermo_enc.sv
// Combinational thermometer decoder: flags codes of contiguous ones from bit 0
// and reports how many ones they hold.
module thermo_enc
  import thermo_pkg::*;
(
  input  logic [DATA_W-1:0]  code,
  output logic [LEVEL_W-1:0] level,
  output logic               valid
);

  // x & (x+1) clears the lowest run of ones; only 2^n-1 codes leave nothing
  // behind (8'hFF wraps to zero, so it qualifies as well).
  always_comb begin
    valid = ((code & (code + DATA_W'(1))) == '0);
    level = '0;
    for (int i = 0; i < DATA_W; i++) begin
      level = level + LEVEL_W'(code[i]);
    end
  end

endmodule

// File: rtl/thermo_monitor.sv
// Two-stage thermometer-code monitor: samples the upstream word, then tracks
// fill level, completed fills and coding errors with a small FSM.
module thermo_monitor
  import thermo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  therm_in,
  input  logic               clr,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         state,
  output logic               full_pulse,
  output logic               code_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   fill_count
);

  logic [DATA_W-1:0]  therm_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  state_t             state_q, state_d;
  logic               full_pulse_q, full_pulse_d;
  logic               code_err_q, code_err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]   fill_count_q, fill_count_d;

  logic [LEVEL_W-1:0] enc_level;
  logic               enc_valid;
  logic               err_evt;
  logic               full_evt;

  thermo_enc u_enc (
    .code  (therm_q),
    .level (enc_level),
    .valid (enc_valid)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      therm_q      <= '0;
      level_q      <= '0;
      state_q      <= ST_EMPTY;
      full_pulse_q <= 1'b0;
      code_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      fill_count_q <= '0;
    end else begin
      therm_q      <= therm_in;
      level_q      <= level_d;
      state_q      <= state_d;
      full_pulse_q <= full_pulse_d;
      code_err_q   <= code_err_d;
      err_sticky_q <= err_sticky_d;
      fill_count_q <= fill_count_d;
    end
  end

  // NOTE: every signal gets a default up front so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    err_evt  = 1'b0;
    full_evt = 1'b0;
    if (enc_valid && enc_level == '0) begin
      // An all-zero word is the upstream restart and recovers from any state.
      state_d = ST_EMPTY;
      level_d = '0;
    end else if (state_q != ST_FAULT) begin
      if (!enc_valid) begin
        err_evt = 1'b1;
      end else if (enc_level == level_q + LEVEL_W'(1)) begin
        level_d = enc_level;
        if (enc_level == FULL_LEVEL) begin
          state_d  = ST_FULL;
          full_evt = 1'b1;
        end else begin
          state_d = ST_FILL;
        end
      end else if (enc_level != level_q) begin
        err_evt = 1'b1;
      end
      if (err_evt) begin
        state_d = ST_FAULT;
      end
    end
  end

  always_comb begin
    full_pulse_d = full_evt;
    code_err_d   = err_evt;
    // A new error outranks a clear on the same cycle.
    err_sticky_d = err_evt | (err_sticky_q & ~clr);
    if (clr) begin
      fill_count_d = '0;
    end else if (full_evt && fill_count_q != COUNT_MAX) begin
      fill_count_d = fill_count_q + CNT_W'(1);
    end else begin
      fill_count_d = fill_count_q;
    end
  end

  assign level      = level_q;
  assign state      = state_q;
  assign full_pulse = full_pulse_q;
  assign code_err   = code_err_q;
  assign err_sticky = err_sticky_q;
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_thermo_monitor.sv
// Directed self-checking bench for thermo_monitor; inputs change on the falling
// edge and outputs are sampled on the falling edge, two rising edges after input.
module tb_thermo_monitor;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic       clk;
  logic       reset;
  logic [7:0] therm_in;
  logic       clr;
  logic [3:0] level;
  logic [1:0] state;
  logic       full_pulse;
  logic       code_err;
  logic       err_sticky;
  logic [7:0] fill_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fill_seq [9] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                               8'h1F, 8'h3F, 8'h7F, 8'hFF};

  thermo_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .therm_in   (therm_in),
    .clr        (clr),
    .level      (level),
    .state      (state),
    .full_pulse (full_pulse),
    .code_err   (code_err),
    .err_sticky (err_sticky),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    therm_in = v;
  endtask

  // Drive and hold until the outputs reflect v.
  task automatic apply(input logic [7:0] v);
    drive(v);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    clr      = 1'b0;
    therm_in = 8'h01;
    repeat (3) @(negedge clk);
    checks++; if (level !== 4'd0)      begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (state !== S_EMPTY)   begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (full_pulse !== 1'b0) begin failures++; $display("FAIL rst_full_pulse got=%b exp=0", full_pulse); end
    checks++; if (code_err !== 1'b0)   begin failures++; $display("FAIL rst_code_err got=%b exp=0", code_err); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rst_err_sticky got=%b exp=0", err_sticky); end
    checks++; if (fill_count !== 8'd0) begin failures++; $display("FAIL rst_fill_count got=%0d exp=0", fill_count); end
    therm_in = 8'h00;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill;
    int pulses = 0;
    logic [3:0] exp_level;
    logic [1:0] exp_state;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      exp_level = (j >= 2) ? 4'(j - 2) : 4'd0;
      exp_state = (exp_level == 4'd0) ? S_EMPTY : (exp_level == 4'd8) ? S_FULL : S_FILL;
      checks++; if (level !== exp_level) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", j, level, exp_level); end
      checks++; if (state !== exp_state) begin failures++; $display("FAIL fill_state[%0d] got=%0d exp=%0d", j, state, exp_state); end
      checks++; if (full_pulse !== (j == 10)) begin failures++; $display("FAIL fill_pulse[%0d] got=%b exp=%b", j, full_pulse, (j == 10)); end
      checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL fill_code_err[%0d] got=%b exp=0", j, code_err); end
      if (full_pulse === 1'b1) pulses++;
      if (j <= 8) therm_in = fill_seq[j];
    end
    checks++; if (pulses !== 1)        begin failures++; $display("FAIL fill_pulse_count got=%0d exp=1", pulses); end
    checks++; if (fill_count !== 8'd1) begin failures++; $display("FAIL fill_count got=%0d exp=1", fill_count); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (full_pulse !== 1'b0) begin failures++; $display("FAIL full_hold_pulse[%0d] got=%b exp=0", j, full_pulse); end
      checks++; if (state !== S_FULL)    begin failures++; $display("FAIL full_hold_state[%0d] got=%0d exp=2", j, state); end
    end
    checks++; if (fill_count !== 8'd1) begin failures++; $display("FAIL full_hold_count got=%0d exp=1", fill_count); end
  endtask

  task automatic test_invalid;
    apply(8'h00);
    apply(8'h01);
    checks++; if (state !== S_FILL) begin failures++; $display("FAIL inv_pre_state got=%0d exp=1", state); end
    drive(8'h05);
    repeat (2) @(negedge clk);
    checks++; if (code_err !== 1'b1)   begin failures++; $display("FAIL inv_code_err got=%b exp=1", code_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL inv_err_sticky got=%b exp=1", err_sticky); end
    checks++; if (state !== S_FAULT)   begin failures++; $display("FAIL inv_state got=%0d exp=3", state); end
    checks++; if (level !== 4'd1)      begin failures++; $display("FAIL inv_level got=%0d exp=1", level); end
    @(negedge clk);
    checks++; if (code_err !== 1'b0)   begin failures++; $display("FAIL inv_pulse_width got=%b exp=0", code_err); end
    apply(8'h00);
    checks++; if (state !== S_EMPTY)   begin failures++; $display("FAIL inv_recover_state got=%0d exp=0", state); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL inv_recover_sticky got=%b exp=1", err_sticky); end
    checks++; if (level !== 4'd0)      begin failures++; $display("FAIL inv_recover_level got=%0d exp=0", level); end
  endtask

  task automatic test_clr;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL clr_err_sticky got=%b exp=0", err_sticky); end
    checks++; if (fill_count !== 8'd0) begin failures++; $display("FAIL clr_fill_count got=%0d exp=0", fill_count); end
    checks++; if (state !== S_EMPTY)   begin failures++; $display("FAIL clr_state got=%0d exp=0", state); end
  endtask

  task automatic test_skip;
    apply(8'h01);
    drive(8'h07);
    repeat (2) @(negedge clk);
    checks++; if (code_err !== 1'b1)   begin failures++; $display("FAIL skip_code_err got=%b exp=1", code_err); end
    checks++; if (state !== S_FAULT)   begin failures++; $display("FAIL skip_state got=%0d exp=3", state); end
    checks++; if (level !== 4'd1)      begin failures++; $display("FAIL skip_level got=%0d exp=1", level); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL skip_err_sticky got=%b exp=1", err_sticky); end
    drive(8'h03);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL skip_no_repeat[%0d] got=%b exp=0", j, code_err); end
      checks++; if (state !== S_FAULT) begin failures++; $display("FAIL skip_hold_state[%0d] got=%0d exp=3", j, state); end
    end
    apply(8'h00);
  endtask

  task automatic test_err_over_clr;
    test_clr();
    drive(8'h05);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (code_err !== 1'b1)   begin failures++; $display("FAIL errclr_code_err got=%b exp=1", code_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL errclr_err_sticky got=%b exp=1", err_sticky); end
    apply(8'h00);
    test_clr();
  endtask

  task automatic test_saturation;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 9; k++) drive(fill_seq[k]);
    end
    repeat (2) @(negedge clk);
    checks++; if (fill_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", fill_count); end
    for (int k = 0; k < 8; k++) drive(fill_seq[k]);
    drive(8'hFF);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (full_pulse !== 1'b1) begin failures++; $display("FAIL satclr_pulse got=%b exp=1", full_pulse); end
    checks++; if (fill_count !== 8'd0) begin failures++; $display("FAIL satclr_count got=%0d exp=0", fill_count); end
    checks++; if (state !== S_FULL)    begin failures++; $display("FAIL satclr_state got=%0d exp=2", state); end
  endtask

  task automatic test_reset_midfill;
    for (int k = 0; k < 6; k++) drive(fill_seq[k]);
    repeat (2) @(negedge clk);
    checks++; if (level !== 4'd5) begin failures++; $display("FAIL mid_pre_level got=%0d exp=5", level); end
    #2 reset = 1'b0;
    #1;
    checks++; if (level !== 4'd0)      begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
    checks++; if (state !== S_EMPTY)   begin failures++; $display("FAIL mid_rst_state got=%0d exp=0", state); end
    checks++; if (full_pulse !== 1'b0) begin failures++; $display("FAIL mid_rst_pulse got=%b exp=0", full_pulse); end
    checks++; if (code_err !== 1'b0)   begin failures++; $display("FAIL mid_rst_code_err got=%b exp=0", code_err); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL mid_rst_sticky got=%b exp=0", err_sticky); end
    checks++; if (fill_count !== 8'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", fill_count); end
    therm_in = 8'h01;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (level !== 4'd1)      begin failures++; $display("FAIL mid_rel_level got=%0d exp=1", level); end
    checks++; if (state !== S_FILL)    begin failures++; $display("FAIL mid_rel_state got=%0d exp=1", state); end
    checks++; if (code_err !== 1'b0)   begin failures++; $display("FAIL mid_rel_code_err got=%b exp=0", code_err); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL mid_rel_sticky got=%b exp=0", err_sticky); end
    checks++; if (full_pulse !== 1'b0) begin failures++; $display("FAIL mid_rel_pulse got=%b exp=0", full_pulse); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_invalid();
    test_clr();
    test_skip();
    test_err_over_clr();
    test_saturation();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
